// File: rtl/data_memory_locked_v2.sv
// ---------------------------------------------------------------------------
// data_memory_locked_v2
//
// Key-locked RV32I data memory for the MEM stage.
//   * DEPTH x 32-bit words, little-endian byte lanes.
//   * LB/LH/LW/LBU/LHU loads with sign/zero extension; SB/SH/SW stores.
//   * Registered read port: rdata/rvalid appear one cycle after req.
//   * Misaligned, out-of-range or illegal-funct3 accesses raise a one-cycle
//     fault pulse and never write.
//   * Unlock FSM: LOCKED -> CHECK -> UNLOCKED, or back to LOCKED on a wrong
//     key, and LOCKOUT after MAX_TRIES wrong keys. Only reset leaves LOCKOUT.
//   * While not unlocked, stores are dropped (no fault) and loads return 0.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active low
//   req        access request this cycle
//   we         1 = store, 0 = load (ignored when req = 0)
//   funct3     RV32I size/sign code
//   addr       byte address
//   wdata      store data, low bytes used for SB/SH
//   key_valid  key_in presented this cycle
//   key_in     candidate key
//   rdata      registered load result
//   rvalid     one-cycle pulse, rdata valid
//   fault      one-cycle pulse, access rejected
//   unlocked   FSM is in UNLOCKED
//   lockout    FSM is in LOCKOUT
// ---------------------------------------------------------------------------
module data_memory_locked_v2 #(
    parameter int                   DEPTH     = 1024,
    parameter int                   KEY_WIDTH = 8,
    parameter logic [KEY_WIDTH-1:0] KEY_VALUE = 'h0F,
    parameter int                   MAX_TRIES = 3,
    parameter int                   INIT_ADDR = 28,
    parameter logic [31:0]          INIT_DATA = 32'h0000_0020
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 key_valid,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic                 fault,
    output logic                 unlocked,
    output logic                 lockout
);

    localparam int AW       = $clog2(DEPTH);
    localparam int INIT_IDX = INIT_ADDR / 4;

    // Decoded view of the current request.
    typedef struct packed {
        logic [AW-1:0] idx;   // word index
        logic [1:0]    lane;  // byte lane inside the word
        logic [1:0]    sz;    // 0 byte, 1 half, 2 word
        logic          sext;  // sign-extend on load
        logic          bad;   // illegal funct3, misaligned or out of range
    } acc_t;

    typedef enum logic [1:0] {
        S_LOCKED,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    // Storage is split into byte lanes so sub-word stores touch only their
    // own lanes. Contents survive reset; only the preload word is non-zero.
    logic [3:0][7:0] mem [DEPTH] = '{INIT_IDX: INIT_DATA, default: 32'h0};

    state_t               state;
    logic [3:0]           fail_cnt;
    logic [KEY_WIDTH-1:0] key_q;

    acc_t        acc;
    logic        bad_f3;
    logic        misal;
    logic        oor;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] ld_val;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wr_en;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        acc      = '0;
        acc.idx  = addr[2 +: AW];
        acc.lane = addr[1:0];
        acc.sz   = funct3[1:0];
        acc.sext = ~funct3[2];

        // Stores only have the three signed-looking codes; loads add the
        // two unsigned variants.
        if (we)
            bad_f3 = (funct3 > 3'd2);
        else
            bad_f3 = (funct3 == 3'd3) || (funct3 > 3'd5);

        misal = ((funct3[1:0] == 2'd1) && addr[0]) ||
                ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));

        oor = ({2'b00, addr[31:2]} >= 32'(DEPTH));

        acc.bad = bad_f3 | misal | oor;
    end

    // ------------------------------------------------------------------
    // Load path: lane select then extension
    // ------------------------------------------------------------------
    always_comb begin
        word    = mem[acc.idx];
        shifted = 32'h0;
        ld_val  = 32'h0;
        case (acc.sz)
            2'd0: begin
                shifted = word >> {acc.lane, 3'b000};
                ld_val  = {{24{acc.sext & shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                // Halfword lane is addr[1]; addr[0] is already faulted.
                shifted = word >> {acc.lane[1], 4'b0000};
                ld_val  = {{16{acc.sext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                shifted = word;
                ld_val  = word;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: byte enables and lane-replicated data
    // ------------------------------------------------------------------
    always_comb begin
        be = 4'h0;
        wd = wdata;
        case (acc.sz)
            2'd0: begin
                be = 4'b0001 << acc.lane;
                wd = {4{wdata[7:0]}};
            end
            2'd1: begin
                be = 4'b0011 << {acc.lane[1], 1'b0};
                wd = {2{wdata[15:0]}};
            end
            default: begin
                be = 4'hF;
                wd = wdata;
            end
        endcase
    end

    // Gating uses the registered unlocked flag, i.e. the state before this
    // edge; reset in the same cycle blocks the write.
    assign wr_en = rst & req & we & unlocked & ~acc.bad;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[acc.idx][i] <= wd[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata  <= 32'h0;
            rvalid <= 1'b0;
            fault  <= 1'b0;
        end else begin
            rvalid <= req & ~we;
            // A locked access is silently dropped, so it cannot fault.
            fault  <= req & unlocked & acc.bad;
            if (req && !we)
                rdata <= (unlocked && !acc.bad) ? ld_val : 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Unlock FSM. unlocked/lockout are registered alongside the state so
    // they always equal "state is UNLOCKED / LOCKOUT".
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_LOCKED;
            fail_cnt <= 4'd0;
            key_q    <= '0;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
        end else begin
            case (state)
                S_LOCKED: begin
                    if (key_valid) begin
                        key_q <= key_in;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (key_q == KEY_VALUE) begin
                        state    <= S_UNLOCKED;
                        fail_cnt <= 4'd0;
                        unlocked <= 1'b1;
                    end else begin
                        fail_cnt <= fail_cnt + 4'd1;
                        if (fail_cnt + 4'd1 == 4'(MAX_TRIES)) begin
                            state   <= S_LOCKOUT;
                            lockout <= 1'b1;
                        end else begin
                            state <= S_LOCKED;
                        end
                    end
                end
                // UNLOCKED and LOCKOUT are held until reset.
                default: ;
            endcase
        end
    end

endmodule
